// File: rtl/reg_transfer_seq_if.sv
// Opcode handshake, register-file inputs and write/flag outputs of reg_transfer_seq.
// master = instruction source plus register blocks, slave = the sequencer.
interface reg_transfer_seq_if;
    logic [7:0] OPCODE;
    logic [7:0] IMM;
    logic       op_valid;
    logic       op_ready;
    logic [7:0] REG_A;
    logic [7:0] REG_X;
    logic [7:0] REG_Y;
    logic [7:0] REG_S;
    logic [7:0] OUT_BUS;
    logic       load_A;
    logic       load_X;
    logic       load_Y;
    logic       load_S;
    logic       flag_N;
    logic       flag_Z;
    logic       load_NZ;
    logic       done;
    logic       illegal;

    modport master (
        output OPCODE, IMM, op_valid, REG_A, REG_X, REG_Y, REG_S,
        input  op_ready, OUT_BUS, load_A, load_X, load_Y, load_S,
        input  flag_N, flag_Z, load_NZ, done, illegal
    );

    modport slave (
        input  OPCODE, IMM, op_valid, REG_A, REG_X, REG_Y, REG_S,
        output op_ready, OUT_BUS, load_A, load_X, load_Y, load_S,
        output flag_N, flag_Z, load_NZ, done, illegal
    );
endinterface

// File: rtl/reg_transfer_seq.sv
// 6502 register-transfer / index inc-dec / index immediate-load sequencer (IDLE->DECODE->EXEC->WRITE).
// Define XFER_INDEX_ARITH_EN to support INX/INY/DEX/DEY; otherwise they decode as illegal.
module reg_transfer_seq (
    input logic               CLK,
    input logic               reset_XFER,
    reg_transfer_seq_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2,
        ST_WRITE  = 2'd3
    } state_t;

    typedef enum logic [3:0] {
        OP_TAX = 4'd0,
        OP_TXA = 4'd1,
        OP_TAY = 4'd2,
        OP_TYA = 4'd3,
        OP_TSX = 4'd4,
        OP_TXS = 4'd5,
        OP_INX = 4'd6,
        OP_DEX = 4'd7,
        OP_INY = 4'd8,
        OP_DEY = 4'd9,
        OP_LDX = 4'd10,
        OP_LDY = 4'd11,
        OP_BAD = 4'd12
    } op_kind_t;

    function automatic op_kind_t classify(input logic [7:0] op);
        op_kind_t kind;
        case (op)
            8'hAA:   kind = OP_TAX;
            8'h8A:   kind = OP_TXA;
            8'hA8:   kind = OP_TAY;
            8'h98:   kind = OP_TYA;
            8'hBA:   kind = OP_TSX;
            8'h9A:   kind = OP_TXS;
            8'hA2:   kind = OP_LDX;
            8'hA0:   kind = OP_LDY;
`ifdef XFER_INDEX_ARITH_EN
            8'hE8:   kind = OP_INX;
            8'hCA:   kind = OP_DEX;
            8'hC8:   kind = OP_INY;
            8'h88:   kind = OP_DEY;
`endif
            default: kind = OP_BAD;
        endcase
        return kind;
    endfunction

    state_t     state_r, state_nx;
    op_kind_t   kind_r, kind_nx;
    op_kind_t   kind_in_s;
    logic [7:0] imm_r, imm_nx;
    logic [7:0] src_s;
    logic [7:0] result_s;
    logic [3:0] target_s;
    logic       accept_s;

    logic       op_ready_r, op_ready_nx;
    logic [7:0] out_bus_r, out_bus_nx;
    logic [3:0] load_r, load_nx;
    logic       flag_n_r, flag_n_nx;
    logic       flag_z_r, flag_z_nx;
    logic       load_nz_r, load_nz_nx;
    logic       done_r, done_nx;
    logic       illegal_r, illegal_nx;

    assign accept_s  = (state_r == ST_IDLE) && bus.op_valid && op_ready_r;
    assign kind_in_s = classify(bus.OPCODE);

    // Source select, result computation and target strobe mask {A,X,Y,S}
    always_comb begin
        src_s    = 8'h00;
        result_s = 8'h00;
        target_s = 4'b0000;
        case (kind_r)
            OP_TAX:  begin src_s = bus.REG_A; target_s = 4'b0100; end
            OP_TXA:  begin src_s = bus.REG_X; target_s = 4'b1000; end
            OP_TAY:  begin src_s = bus.REG_A; target_s = 4'b0010; end
            OP_TYA:  begin src_s = bus.REG_Y; target_s = 4'b1000; end
            OP_TSX:  begin src_s = bus.REG_S; target_s = 4'b0100; end
            OP_TXS:  begin src_s = bus.REG_X; target_s = 4'b0001; end
            OP_LDX:  begin src_s = imm_r;     target_s = 4'b0100; end
            OP_LDY:  begin src_s = imm_r;     target_s = 4'b0010; end
`ifdef XFER_INDEX_ARITH_EN
            OP_INX, OP_DEX: begin src_s = bus.REG_X; target_s = 4'b0100; end
            OP_INY, OP_DEY: begin src_s = bus.REG_Y; target_s = 4'b0010; end
`endif
            default: begin src_s = 8'h00;     target_s = 4'b0000; end
        endcase
`ifdef XFER_INDEX_ARITH_EN
        // Modulo-256 step; carry is intentionally dropped
        case (kind_r)
            OP_INX, OP_INY: result_s = src_s + 8'h01;
            OP_DEX, OP_DEY: result_s = src_s - 8'h01;
            default:        result_s = src_s;
        endcase
`else
        result_s = src_s;
`endif
    end

    // Next-state and next registered-output values
    always_comb begin
        state_nx   = state_r;
        kind_nx    = kind_r;
        imm_nx     = imm_r;
        out_bus_nx = out_bus_r;
        load_nx    = 4'b0000;
        flag_n_nx  = flag_n_r;
        flag_z_nx  = flag_z_r;
        load_nz_nx = 1'b0;
        done_nx    = 1'b0;
        illegal_nx = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    kind_nx    = kind_in_s;
                    imm_nx     = bus.IMM;
                    illegal_nx = (kind_in_s == OP_BAD);
                    state_nx   = ST_DECODE;
                end else begin
                    state_nx   = ST_IDLE;
                end
            end
            ST_DECODE: begin
                if (kind_r == OP_BAD) begin
                    state_nx = ST_IDLE;
                end else begin
                    state_nx = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_nx   = ST_WRITE;
                out_bus_nx = result_s;
                load_nx    = target_s;
                done_nx    = 1'b1;
                if (kind_r != OP_TXS) begin
                    load_nz_nx = 1'b1;
                    flag_n_nx  = result_s[7];
                    flag_z_nx  = (result_s == 8'h00);
                end else begin
                    load_nz_nx = 1'b0;
                end
            end
            ST_WRITE: state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
        op_ready_nx = (state_nx == ST_IDLE);
    end

    // State and output registers; reset aborts any in-flight instruction
    always_ff @(posedge CLK or posedge reset_XFER) begin
        if (reset_XFER) begin
            state_r    <= ST_IDLE;
            kind_r     <= OP_BAD;
            imm_r      <= 8'h00;
            op_ready_r <= 1'b1;
            out_bus_r  <= 8'h00;
            load_r     <= 4'b0000;
            flag_n_r   <= 1'b0;
            flag_z_r   <= 1'b0;
            load_nz_r  <= 1'b0;
            done_r     <= 1'b0;
            illegal_r  <= 1'b0;
        end else begin
            state_r    <= state_nx;
            kind_r     <= kind_nx;
            imm_r      <= imm_nx;
            op_ready_r <= op_ready_nx;
            out_bus_r  <= out_bus_nx;
            load_r     <= load_nx;
            flag_n_r   <= flag_n_nx;
            flag_z_r   <= flag_z_nx;
            load_nz_r  <= load_nz_nx;
            done_r     <= done_nx;
            illegal_r  <= illegal_nx;
        end
    end

    assign bus.op_ready = op_ready_r;
    assign bus.OUT_BUS  = out_bus_r;
    assign bus.load_A   = load_r[3];
    assign bus.load_X   = load_r[2];
    assign bus.load_Y   = load_r[1];
    assign bus.load_S   = load_r[0];
    assign bus.flag_N   = flag_n_r;
    assign bus.flag_Z   = flag_z_r;
    assign bus.load_NZ  = load_nz_r;
    assign bus.done     = done_r;
    assign bus.illegal  = illegal_r;

endmodule

// File: tb/tb_reg_transfer_seq.sv
// Scoreboard bench for reg_transfer_seq: expectations queued at acceptance, checked on output events.
module tb_reg_transfer_seq;

    typedef struct {
        logic       illegal;
        logic [3:0] strobes;
        logic       nz;
        logic [7:0] bus;
        logic       n;
        logic       z;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    reg_transfer_seq_if xif ();

    reg_transfer_seq dut (
        .CLK        (clk),
        .reset_XFER (rst),
        .bus        (xif)
    );

    // Register blocks fed by the DUT's strobes
    logic [7:0] reg_a = 8'h80, reg_x = 8'h11, reg_y = 8'h00, reg_s = 8'hFF;
    assign xif.REG_A = reg_a;
    assign xif.REG_X = reg_x;
    assign xif.REG_Y = reg_y;
    assign xif.REG_S = reg_s;
    always @(posedge clk) begin
        if (xif.load_A) reg_a <= xif.OUT_BUS;
        if (xif.load_X) reg_x <= xif.OUT_BUS;
        if (xif.load_Y) reg_y <= xif.OUT_BUS;
        if (xif.load_S) reg_s <= xif.OUT_BUS;
    end

    // Golden architectural state, advanced in program order
    logic [7:0] g_a = 8'h80, g_x = 8'h11, g_y = 8'h00, g_s = 8'hFF;
    logic [7:0] g_bus = 8'h00;
    logic       g_n = 1'b0, g_z = 1'b0;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   last_done = 0, prev_done = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [7:0] op, input logic [7:0] imm);
        exp_t e;
        logic [7:0] res;
        e.illegal = 1'b0;
        e.strobes = 4'b0000;
        e.nz      = 1'b1;
        res       = 8'h00;
        case (op)
            8'hAA: begin res = g_a; g_x = res; e.strobes = 4'b0100; end
            8'h8A: begin res = g_x; g_a = res; e.strobes = 4'b1000; end
            8'hA8: begin res = g_a; g_y = res; e.strobes = 4'b0010; end
            8'h98: begin res = g_y; g_a = res; e.strobes = 4'b1000; end
            8'hBA: begin res = g_s; g_x = res; e.strobes = 4'b0100; end
            8'h9A: begin res = g_x; g_s = res; e.strobes = 4'b0001; e.nz = 1'b0; end
            8'hA2: begin res = imm; g_x = res; e.strobes = 4'b0100; end
            8'hA0: begin res = imm; g_y = res; e.strobes = 4'b0010; end
`ifdef XFER_INDEX_ARITH_EN
            8'hE8: begin res = g_x + 8'h01; g_x = res; e.strobes = 4'b0100; end
            8'hCA: begin res = g_x - 8'h01; g_x = res; e.strobes = 4'b0100; end
            8'hC8: begin res = g_y + 8'h01; g_y = res; e.strobes = 4'b0010; end
            8'h88: begin res = g_y - 8'h01; g_y = res; e.strobes = 4'b0010; end
`endif
            default: begin e.illegal = 1'b1; e.nz = 1'b0; end
        endcase
        if (!e.illegal) g_bus = res;
        if (e.nz) begin
            g_n = res[7];
            g_z = (res == 8'h00);
        end
        e.bus = g_bus;
        e.n   = g_n;
        e.z   = g_z;
        sb.push_back(e);
    endtask

    // Output monitor: every strobe/pulse cycle must match the oldest expectation
    always @(negedge clk) begin
        if (!rst) begin
            if (xif.done) begin
                prev_done = last_done;
                last_done = cyc;
            end
            if (xif.load_A | xif.load_X | xif.load_Y | xif.load_S |
                xif.load_NZ | xif.done | xif.illegal) begin
                if (sb.size() == 0) begin
                    check_val("unexpected_event",
                              {9'd0, xif.load_A, xif.load_X, xif.load_Y, xif.load_S,
                               xif.load_NZ, xif.done, xif.illegal}, 16'h0000);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check_val("illegal", xif.illegal, e.illegal);
                    check_val("done", xif.done, !e.illegal);
                    check_val("strobes", {xif.load_A, xif.load_X, xif.load_Y, xif.load_S}, e.strobes);
                    check_val("load_nz", xif.load_NZ, e.nz);
                    check_val("out_bus", xif.OUT_BUS, e.bus);
                    check_val("flag_n", xif.flag_N, e.n);
                    check_val("flag_z", xif.flag_Z, e.z);
                end
            end
        end
    end

    task automatic issue(input logic [7:0] op, input logic [7:0] imm, input bit hold);
        int waited;
        waited = 0;
        @(negedge clk);
        xif.OPCODE   = op;
        xif.IMM      = imm;
        xif.op_valid = 1'b1;
        while (!xif.op_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check_val("accept", xif.op_ready, 1'b1);
        push_exp(op, imm);
        @(posedge clk);
        #1;
        if (!hold) xif.op_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        @(negedge clk);
        while ((sb.size() != 0 || !xif.op_ready) && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_val("drain", sb.size(), 0);
    endtask

    logic [7:0] ops [8] = '{8'h8A, 8'hA8, 8'hBA, 8'hC8, 8'hCA, 8'h88, 8'hE8, 8'h98};
    logic [7:0] sv_a, sv_x, sv_y, sv_s;

    initial begin
        xif.OPCODE   = 8'h00;
        xif.IMM      = 8'h00;
        xif.op_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_op_ready", xif.op_ready, 1'b1);
        check_val("rst_out_bus", xif.OUT_BUS, 8'h00);
        check_val("rst_strobes", {xif.load_A, xif.load_X, xif.load_Y, xif.load_S, xif.load_NZ}, 5'b00000);
        check_val("rst_flags", {xif.flag_N, xif.flag_Z}, 2'b00);
        check_val("rst_pulses", {xif.done, xif.illegal}, 2'b00);
        rst = 1'b0;

        issue(8'hAA, 8'h00, 1'b0);          // TAX, A=80
        issue(8'hA2, 8'h00, 1'b0);          // LDX#00
        issue(8'hA0, 8'h90, 1'b0);          // LDY#90 -> N=1 Z=0
        issue(8'h9A, 8'h00, 1'b0);          // TXS with X=00, flags held
        issue(8'hA2, 8'hFF, 1'b0);          // LDX#FF
        issue(8'hE8, 8'h00, 1'b0);          // INX: 00 (or illegal)
        issue(8'hA0, 8'h00, 1'b0);          // LDY#00
        issue(8'h88, 8'h00, 1'b0);          // DEY: FF (or illegal)
        wait_drain();

        // Unsupported opcode: ready again two cycles after acceptance
        issue(8'hEA, 8'h00, 1'b0);
        @(negedge clk);
        check_val("illegal_ready_c1", xif.op_ready, 1'b0);
        @(negedge clk);
        check_val("illegal_ready_c2", xif.op_ready, 1'b1);
        wait_drain();

        // Back-to-back with op_valid held while busy
        issue(8'hA2, 8'h05, 1'b1);
`ifdef XFER_INDEX_ARITH_EN
        issue(8'hE8, 8'h00, 1'b0);
`else
        issue(8'h8A, 8'h00, 1'b0);
`endif
        wait_drain();
        check_val("done_spacing", last_done - prev_done, 4);

        for (int i = 0; i < 8; i++) begin
            issue(ops[i], 8'($urandom_range(0, 255)), 1'b0);
        end
        issue(8'hA0, 8'hC3, 1'b0);          // LDY#C3: nonzero bus before reset
        wait_drain();

        // Reset during EXEC of TYA aborts it
        sv_a = g_a; sv_x = g_x; sv_y = g_y; sv_s = g_s;
        issue(8'h98, 8'h00, 1'b0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check_val("abort_op_ready", xif.op_ready, 1'b1);
        check_val("abort_out_bus", xif.OUT_BUS, 8'h00);
        check_val("abort_load_a", xif.load_A, 1'b0);
        sb.delete();
        g_a = sv_a; g_x = sv_x; g_y = sv_y; g_s = sv_s;
        g_bus = 8'h00; g_n = 1'b0; g_z = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check_val("abort_reg_a", reg_a, sv_a);
        issue(8'h98, 8'h00, 1'b0);
        wait_drain();
        check_val("final_reg_a", reg_a, g_a);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
